// File: rtl/f_bus_master.sv
// f_bus_master: file-register bus initiator running one read-compute-writeback operation per request.
module f_bus_master #(
  parameter int ADRS_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic              op_d,
  input  logic [ADRS_W-1:0] op_f,
  input  logic [DATA_W-1:0] w_in,
  input  logic              c_in,
  input  logic [ADRS_W-1:0] fsr_in,
  output logic [ADRS_W-1:0] f_adrs,
  output logic              f_wr,
  output logic [DATA_W-1:0] f_in_data,
  input  logic [DATA_W-1:0] f_out_data,
  output logic              w_wr,
  output logic [DATA_W-1:0] w_out,
  output logic              C_new,
  output logic              DC_new,
  output logic              Z_new,
  output logic              C_en,
  output logic              DC_en,
  output logic              Z_en,
  output logic              skip,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RD, WB} state_t;
  state_t state, nxt;
  logic [3:0] code_q;
  logic d_q, c_q, c_h, dc_h, z_h;
  logic [DATA_W-1:0] w_q, opnd_q, b, r;
  logic [ADRS_W-1:0] eff_q;
  logic [DATA_W:0] sum;
  logic sub, wb, ce, dce, ze, c_v, dc_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      code_q <= '0;
      d_q    <= 1'b0;
      w_q    <= '0;
      c_q    <= 1'b0;
      eff_q  <= '0;
      opnd_q <= '0;
      c_h    <= 1'b0;
      dc_h   <= 1'b0;
      z_h    <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && op_valid) begin
        code_q <= op_code;
        d_q    <= op_d;
        w_q    <= w_in;
        c_q    <= c_in;
        eff_q  <= (op_f == '0) ? fsr_in : op_f;
      end
      // INDF dereferenced through FSR=0 reads as zero
      if (state == RD) opnd_q <= (eff_q == '0) ? '0 : f_out_data;
      if (wb && ce) c_h <= c_v;
      if (wb && dce) dc_h <= dc_v;
      if (wb && ze) z_h <= (r == '0);
    end
  end
  always_comb begin
    nxt = state;
    nxt = (state == IDLE) ? (op_valid ? RD : IDLE) : (state == RD) ? WB : IDLE;
  end
  assign sub  = (code_q == 4'h2);
  assign b    = sub ? ~w_q : w_q;
  assign sum  = {1'b0, opnd_q} + {1'b0, b} + {{DATA_W{1'b0}}, sub};
  assign dc_v = ({1'b0, opnd_q[3:0]} + {1'b0, b[3:0]} + {4'b0, sub}) > 5'd15;
  assign c_v  = (code_q == 4'hC) ? opnd_q[0] : (code_q == 4'hD) ? opnd_q[DATA_W-1] : sum[DATA_W];
  always_comb begin
    r = '0;
    case (code_q)
      4'h0:              r = w_q;
      4'h1:              r = '0;
      4'h2, 4'h7:        r = sum[DATA_W-1:0];
      4'h3, 4'hB:        r = opnd_q - DATA_W'(1);
      4'h4:              r = opnd_q | w_q;
      4'h5:              r = opnd_q & w_q;
      4'h6:              r = opnd_q ^ w_q;
      4'h8:              r = opnd_q;
      4'h9:              r = ~opnd_q;
      4'hA, 4'hF:        r = opnd_q + DATA_W'(1);
      4'hC:              r = {c_q, opnd_q[DATA_W-1:1]};
      4'hD:              r = {opnd_q[DATA_W-2:0], c_q};
      default:           r = {opnd_q[DATA_W/2-1:0], opnd_q[DATA_W-1:DATA_W/2]};
    endcase
  end
  assign ze  = (code_q >= 4'h1) && (code_q <= 4'hA);
  assign ce  = (code_q == 4'h2) || (code_q == 4'h7) || (code_q == 4'hC) || (code_q == 4'hD);
  assign dce = (code_q == 4'h2) || (code_q == 4'h7);
  assign wb  = (state == WB) && !rst;
  assign op_ready  = (state == IDLE);
  assign f_adrs    = eff_q;
  assign done      = wb;
  assign f_wr      = wb && (code_q == 4'h0 || d_q) && (eff_q != '0);
  assign w_wr      = wb && (code_q != 4'h0) && !d_q;
  assign f_in_data = wb ? r : '0;
  assign w_out     = wb ? r : '0;
  assign C_en      = wb && ce;
  assign DC_en     = wb && dce;
  assign Z_en      = wb && ze;
  assign C_new     = C_en ? c_v : c_h;
  assign DC_new    = DC_en ? dc_v : dc_h;
  assign Z_new     = Z_en ? (r == '0) : z_h;
  assign skip      = wb && (code_q == 4'hB || code_q == 4'hF) && (r == '0);
endmodule

// File: tb/tb_f_bus_master.sv
// tb_f_bus_master: randomized and directed checks of f_bus_master against an arithmetic reference model.
module tb_f_bus_master;
  logic clk = 0, rst = 1, op_valid = 0, op_d = 0, c_in = 0;
  logic [3:0] op_code = 0;
  logic [4:0] op_f = 0, fsr_in = 0, f_adrs;
  logic [7:0] w_in = 0, f_in_data, f_out_data, w_out;
  logic op_ready, f_wr, w_wr, C_new, DC_new, Z_new, C_en, DC_en, Z_en, skip, done;
  logic [7:0] bus_mem [32];
  logic [7:0] ref_mem [32];
  logic exp_c = 0, exp_dc = 0, exp_z = 0;
  logic [7:0] obs_fin, obs_wout;
  logic obs_c, obs_z, obs_skip, obs_fwr;
  int n_cmp = 0, n_bad = 0;

  f_bus_master dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_d(op_d), .op_f(op_f), .w_in(w_in), .c_in(c_in), .fsr_in(fsr_in),
    .f_adrs(f_adrs), .f_wr(f_wr), .f_in_data(f_in_data), .f_out_data(f_out_data),
    .w_wr(w_wr), .w_out(w_out), .C_new(C_new), .DC_new(DC_new), .Z_new(Z_new),
    .C_en(C_en), .DC_en(DC_en), .Z_en(Z_en), .skip(skip), .done(done)
  );

  always #5 clk = ~clk;
  assign f_out_data = bus_mem[f_adrs];
  always @(posedge clk) if (f_wr) bus_mem[f_adrs] <= f_in_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setmem(input logic [4:0] a, input logic [7:0] v);
    bus_mem[a] = v;
    ref_mem[a] = v;
  endtask

  // called just after a negedge with the DUT idle; returns at a negedge with the DUT idle
  task automatic run_op(input logic [3:0] op, input logic d, input logic [4:0] f,
                        input logic [7:0] w, input logic c, input logic [4:0] fsr);
    logic [4:0] eff;
    int F, W, r;
    logic cv, dcv, ze, ce, dce, skp, fw, ww;
    eff = (f == 0) ? fsr : f;
    F = (eff == 0) ? 0 : int'(ref_mem[eff]);
    W = int'(w);
    cv = 0; dcv = 0; ce = 0; dce = 0; r = 0;
    ze = (op >= 1 && op <= 10);
    case (op)
      0: r = W;
      1: r = 0;
      2: begin r = (F - W + 256) % 256; ce = 1; dce = 1; cv = F >= W; dcv = (F % 16) >= (W % 16); end
      3, 11: r = (F + 255) % 256;
      4: r = F | W;
      5: r = F & W;
      6: r = F ^ W;
      7: begin r = (F + W) % 256; ce = 1; dce = 1; cv = (F + W) > 255; dcv = (F % 16 + W % 16) > 15; end
      8: r = F;
      9: r = 255 - F;
      10, 15: r = (F + 1) % 256;
      12: begin r = c * 128 + F / 2; ce = 1; cv = F % 2; end
      13: begin r = (F * 2) % 256 + c; ce = 1; cv = F / 128; end
      default: r = (F % 16) * 16 + F / 16;
    endcase
    skp = (op == 11 || op == 15) && r == 0;
    fw = (op == 0 || d) && eff != 0;
    ww = op != 0 && !d;
    op_code = op; op_d = d; op_f = f; w_in = w; c_in = c; fsr_in = fsr; op_valid = 1;
    check("ready_idle", op_ready, 1);
    @(posedge clk); @(negedge clk);
    op_valid = 0;
    check("ready_rd", op_ready, 0);
    check("adrs_rd", f_adrs, eff);
    check("done_rd", done, 0);
    @(posedge clk); @(negedge clk);
    check("done_wb", done, 1);
    check("f_wr", f_wr, fw);
    if (fw) begin
      check("adrs_wb", f_adrs, eff);
      check("f_in_data", f_in_data, r);
    end
    check("w_wr", w_wr, ww);
    if (ww) check("w_out", w_out, r);
    check("C_en", C_en, ce);
    check("DC_en", DC_en, dce);
    check("Z_en", Z_en, ze);
    check("C_new", C_new, ce ? cv : exp_c);
    check("DC_new", DC_new, dce ? dcv : exp_dc);
    check("Z_new", Z_new, ze ? (r == 0) : exp_z);
    check("skip", skip, skp);
    obs_fin = f_in_data; obs_wout = w_out; obs_c = C_new; obs_z = Z_new; obs_skip = skip; obs_fwr = f_wr;
    if (fw) ref_mem[eff] = 8'(r);
    if (ce) exp_c = cv;
    if (dce) exp_dc = dcv;
    if (ze) exp_z = (r == 0);
    @(posedge clk); @(negedge clk);
    check("done_after", done, 0);
  endtask

  initial begin
    int rdy, dn;
    logic [4:0] f, fs;
    for (int i = 0; i < 32; i++) setmem(5'(i), 8'($urandom));
    setmem(0, 8'hA5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", op_ready, 1);
    check("rst_fwr", f_wr, 0);
    check("rst_wwr", w_wr, 0);
    check("rst_done", done, 0);
    check("rst_adrs", f_adrs, 0);
    check("rst_fin", f_in_data, 0);
    check("rst_wout", w_out, 0);
    rst = 0;
    @(negedge clk);
    setmem(5'h10, 8'hF1);
    run_op(4'h7, 1, 5'h10, 8'h0F, 0, 0);
    check("addwf_data", obs_fin, 8'h00);
    check("addwf_c", obs_c, 1);
    check("addwf_z", obs_z, 1);
    setmem(5'h12, 8'h7F);
    run_op(4'hA, 1, 5'h00, 8'h00, 0, 5'h12);
    check("indf_data", obs_fin, 8'h80);
    check("indf_z", obs_z, 0);
    run_op(4'h8, 0, 5'h00, 8'h33, 0, 5'h00);
    check("indf0_wout", obs_wout, 8'h00);
    check("indf0_z", obs_z, 1);
    run_op(4'h0, 1, 5'h00, 8'h55, 0, 5'h00);
    check("indf0_nowr", obs_fwr, 0);
    setmem(5'h14, 8'h01);
    run_op(4'hB, 0, 5'h14, 8'h00, 0, 0);
    check("decfsz_skip1", obs_skip, 1);
    setmem(5'h14, 8'h02);
    run_op(4'hB, 0, 5'h14, 8'h00, 0, 0);
    check("decfsz_skip0", obs_skip, 0);
    setmem(5'h15, 8'h05);
    run_op(4'h2, 1, 5'h15, 8'h06, 0, 0);
    check("subwf_data", obs_fin, 8'hFF);
    check("subwf_c", obs_c, 0);
    setmem(5'h16, 8'h80);
    run_op(4'hD, 1, 5'h16, 8'h00, 1, 0);
    check("rlf_data", obs_fin, 8'h01);
    check("rlf_c", obs_c, 1);
    setmem(5'h17, 8'hFF);
    run_op(4'hA, 1, 5'h17, 8'h00, 0, 0);
    check("incf_wrap", obs_fin, 8'h00);
    setmem(5'h18, 8'h00);
    run_op(4'h3, 1, 5'h18, 8'h00, 0, 0);
    check("decf_wrap", obs_fin, 8'hFF);
    check("decf_wrap_z", obs_z, 0);
    for (int n = 0; n < 150; n++) begin
      f  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      fs = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      run_op(4'($urandom_range(0, 15)), 1'($urandom), f, 8'($urandom), 1'($urandom), fs);
    end
    rdy = 0; dn = 0;
    op_code = 4'h1; op_d = 0; op_f = 5'h05; op_valid = 1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      rdy += int'(op_ready);
      dn += int'(done);
      if (k == 8) op_valid = 0;
      @(posedge clk);
    end
    exp_z = 1;
    @(negedge clk);
    check("cont_accepts", rdy, 3);
    check("cont_dones", dn, 3);
    setmem(5'h10, 8'h11);
    op_code = 4'h7; op_d = 1; op_f = 5'h10; w_in = 8'h22; op_valid = 1;
    @(posedge clk); @(negedge clk);
    op_valid = 0; rst = 1;
    @(posedge clk); @(negedge clk);
    check("rstrd_fwr", f_wr, 0);
    check("rstrd_wwr", w_wr, 0);
    check("rstrd_done", done, 0);
    rst = 0; exp_c = 0; exp_dc = 0; exp_z = 0;
    @(posedge clk); @(negedge clk);
    check("rstrd_ready", op_ready, 1);
    check("rstrd_done2", done, 0);
    check("rstrd_nowrite", bus_mem[5'h10], ref_mem[5'h10]);
    op_code = 4'h7; op_d = 1; op_f = 5'h10; w_in = 8'hEF; op_valid = 1;
    @(posedge clk); @(negedge clk);
    op_valid = 0;
    @(posedge clk); @(negedge clk);
    rst = 1;
    #1;
    check("rstwb_fwr", f_wr, 0);
    check("rstwb_done", done, 0);
    check("rstwb_zen", Z_en, 0);
    check("rstwb_cen", C_en, 0);
    @(posedge clk); @(negedge clk);
    rst = 0;
    @(posedge clk); @(negedge clk);
    check("rstwb_ready", op_ready, 1);
    check("rstwb_nowrite", bus_mem[5'h10], ref_mem[5'h10]);
    check("rstwb_z", Z_new, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
